// File: rtl/pacman_input_ctrl.sv
// Pac-Man keyboard input controller: HID keycode debounce, pause toggle, and tile-aligned turn probing.
// Optional macro PACMAN_INSTANT_REVERSE_EN commits opposite-direction turns immediately without a probe.
module pacman_input_ctrl #(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       at_tile,
    output logic       probe_valid,
    output logic [1:0] probe_dir,
    input  logic       probe_done,
    input  logic       probe_open,
    output logic [1:0] cur_dir,
    output logic       moving,
    output logic       paused,
    output logic       pend_valid
);

`ifdef PACMAN_INSTANT_REVERSE_EN
    localparam bit INSTANT_REVERSE = 1'b1;
`else
    localparam bit INSTANT_REVERSE = 1'b0;
`endif

    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [2:0] {K_NONE, K_UP, K_LEFT, K_DOWN, K_RIGHT, K_PAUSE} key_t;
    typedef enum logic [1:0] {IDLE, PROBE, COMMIT} state_t;

    state_t     state, state_next;
    key_t       key, last_code;
    logic [1:0] key_dir;
    logic [3:0] cnt, cnt_next;
    logic       same, accept, acc_dir, acc_pause;
    logic       committed;
    logic [1:0] pend_dir, probe_dir_r, commit_dir;
    logic       stale, pause_tog;
    logic       go_probe, go_reverse, probe_abort, rev_hit;

    always_comb begin
        key     = K_NONE;
        key_dir = 2'd0;
        case (keycode)
            8'h1A: begin key = K_UP;    key_dir = 2'd0; end
            8'h04: begin key = K_LEFT;  key_dir = 2'd1; end
            8'h16: begin key = K_DOWN;  key_dir = 2'd2; end
            8'h07: begin key = K_RIGHT; key_dir = 2'd3; end
            8'h2C: key = K_PAUSE;
            default: key = K_NONE;
        endcase
    end

    // Acceptance fires only on the tick where the count first reaches DEB, so a
    // count saturated at DEB never re-accepts a held key.
    always_comb begin
        same      = (key == last_code);
        cnt_next  = same ? ((cnt == 4'hF) ? cnt : cnt + 4'd1) : 4'd1;
        accept    = frame_tick && (key != K_NONE) && (cnt_next == DEB) && !(same && cnt == DEB);
        acc_dir   = accept && (key != K_PAUSE);
        acc_pause = accept && (key == K_PAUSE);
    end

    always_comb begin
        state_next  = state;
        go_probe    = 1'b0;
        go_reverse  = 1'b0;
        rev_hit     = INSTANT_REVERSE && acc_dir && moving && (key_dir == (cur_dir ^ 2'd2));
        probe_abort = stale || pause_tog || paused || acc_pause ||
                      (acc_dir && key_dir != probe_dir_r);
        case (state)
            IDLE: begin
                if (rev_hit) begin
                    state_next = COMMIT;
                    go_reverse = 1'b1;
                end else if (pend_valid && at_tile && !paused) begin
                    state_next = PROBE;
                    go_probe   = 1'b1;
                end
            end
            PROBE: begin
                if (probe_done) begin
                    if (!probe_abort && probe_open)
                        state_next = COMMIT;
                    else
                        state_next = IDLE;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            last_code   <= K_NONE;
            cnt         <= '0;
            paused      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_dir    <= '0;
            probe_dir_r <= '0;
            commit_dir  <= '0;
            stale       <= 1'b0;
            pause_tog   <= 1'b0;
            cur_dir     <= 2'd1;
            committed   <= 1'b0;
        end else begin
            state <= state_next;
            if (frame_tick) begin
                last_code <= key;
                cnt       <= cnt_next;
            end
            if (acc_pause)
                paused <= !paused;

            if (paused)
                pend_valid <= 1'b0;
            else if (acc_dir) begin
                pend_dir   <= key_dir;
                pend_valid <= 1'b1;
            end else if (state == COMMIT)
                pend_valid <= 1'b0;

            // A direction accepted on the launch edge is probed instead of the older pending one.
            if (go_probe) begin
                probe_dir_r <= acc_dir ? key_dir : pend_dir;
                stale       <= 1'b0;
                pause_tog   <= 1'b0;
            end
            if (state == PROBE) begin
                if (acc_dir && key_dir != probe_dir_r)
                    stale <= 1'b1;
                if (acc_pause)
                    pause_tog <= 1'b1;
            end

            if (go_reverse)
                commit_dir <= key_dir;
            else if (state == PROBE && state_next == COMMIT)
                commit_dir <= probe_dir_r;

            if (state == COMMIT) begin
                cur_dir   <= commit_dir;
                committed <= 1'b1;
            end
        end
    end

    assign probe_valid = (state == PROBE);
    assign probe_dir   = probe_dir_r;
    assign moving      = committed && !paused;

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Self-checking bench for pacman_input_ctrl: decode table, turn/pause/reset sequences,
// and a randomized debounce/pause run against a run-length reference model.
module tb_pacman_input_ctrl;
    localparam int unsigned D = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = '0;
    logic       frame_tick = 1'b0;
    logic       at_tile = 1'b0;
    logic       probe_valid;
    logic [1:0] probe_dir;
    logic       probe_done = 1'b0;
    logic       probe_open = 1'b0;
    logic [1:0] cur_dir;
    logic       moving;
    logic       paused;
    logic       pend_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pacman_input_ctrl #(.DEBOUNCE_FRAMES(D)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick),
        .at_tile(at_tile), .probe_valid(probe_valid), .probe_dir(probe_dir),
        .probe_done(probe_done), .probe_open(probe_open), .cur_dir(cur_dir),
        .moving(moving), .paused(paused), .pend_valid(pend_valid)
    );

    typedef struct {
        logic [7:0] code;
        bit         is_dir;
        bit         is_pause;
        logic [1:0] dir;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] code);
        keycode = code;
        repeat (D) tick();
    endtask

    task automatic do_reset();
        keycode = '0; frame_tick = 0; at_tile = 0; probe_done = 0; probe_open = 0;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    // Launch a probe from a pending direction and let it complete with the given result.
    task automatic probe_cycle(input bit open);
        at_tile = 1'b1;
        step();
        at_tile = 1'b0;
        probe_done = 1'b1;
        probe_open = open;
        step();
        probe_done = 1'b0;
        step();
    endtask

    // Reference classes: 0 none, 1..4 directions up/left/down/right, 5 pause.
    function automatic int key_class(input logic [7:0] code);
        case (code)
            8'h1A: return 1;
            8'h04: return 2;
            8'h16: return 3;
            8'h07: return 4;
            8'h2C: return 5;
            default: return 0;
        endcase
    endfunction

    initial begin
        vec_t tbl[8];
        logic [7:0] picks[7];
        int  run_key, run_len, k;
        bit  m_paused, m_pend, acc, was_paused;

        tbl[0] = '{code: 8'h1A, is_dir: 1, is_pause: 0, dir: 2'd0};
        tbl[1] = '{code: 8'h04, is_dir: 1, is_pause: 0, dir: 2'd1};
        tbl[2] = '{code: 8'h16, is_dir: 1, is_pause: 0, dir: 2'd2};
        tbl[3] = '{code: 8'h07, is_dir: 1, is_pause: 0, dir: 2'd3};
        tbl[4] = '{code: 8'h2C, is_dir: 0, is_pause: 1, dir: 2'd0};
        tbl[5] = '{code: 8'h00, is_dir: 0, is_pause: 0, dir: 2'd0};
        tbl[6] = '{code: 8'h1B, is_dir: 0, is_pause: 0, dir: 2'd0};
        tbl[7] = '{code: 8'hFF, is_dir: 0, is_pause: 0, dir: 2'd0};

        do_reset();
        check("rst_probe_valid", {7'd0, probe_valid}, 8'd0);
        check("rst_probe_dir", {6'd0, probe_dir}, 8'd0);
        check("rst_cur_dir", {6'd0, cur_dir}, 8'd1);
        check("rst_moving", {7'd0, moving}, 8'd0);
        check("rst_paused", {7'd0, paused}, 8'd0);
        check("rst_pend_valid", {7'd0, pend_valid}, 8'd0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            press(tbl[i].code);
            check("tbl_pend", {7'd0, pend_valid}, {7'd0, tbl[i].is_dir});
            check("tbl_paused", {7'd0, paused}, {7'd0, tbl[i].is_pause});
            if (tbl[i].is_dir) begin
                at_tile = 1'b1;
                step();
                at_tile = 1'b0;
                check("tbl_probe_valid", {7'd0, probe_valid}, 8'd1);
                check("tbl_probe_dir", {6'd0, probe_dir}, {6'd0, tbl[i].dir});
                probe_done = 1'b1; probe_open = 1'b1;
                step();
                probe_done = 1'b0;
                step();
                check("tbl_cur_dir", {6'd0, cur_dir}, {6'd0, tbl[i].dir});
                check("tbl_moving", {7'd0, moving}, 8'd1);
                check("tbl_pend_clr", {7'd0, pend_valid}, 8'd0);
            end
        end

        // Single-tick press is not accepted.
        do_reset();
        keycode = 8'h1A;
        tick();
        keycode = 8'h00;
        tick();
        tick();
        check("short_press_pend", {7'd0, pend_valid}, 8'd0);

        // Blocked probe retries at the next tile; probe outputs hold while waiting.
        do_reset();
        press(8'h16);
        at_tile = 1'b1;
        step();
        at_tile = 1'b0;
        repeat (3) begin
            step();
            check("hold_probe_valid", {7'd0, probe_valid}, 8'd1);
            check("hold_probe_dir", {6'd0, probe_dir}, 8'd2);
        end
        probe_done = 1'b1; probe_open = 1'b0;
        step();
        probe_done = 1'b0;
        check("blocked_idle", {7'd0, probe_valid}, 8'd0);
        check("blocked_pend", {7'd0, pend_valid}, 8'd1);
        check("blocked_cur_dir", {6'd0, cur_dir}, 8'd1);
        probe_cycle(1'b1);
        check("retry_cur_dir", {6'd0, cur_dir}, 8'd2);

        // Pause toggle, moving suppression, and discard of directions while paused.
        do_reset();
        press(8'h07);
        probe_cycle(1'b1);
        press(8'h2C);
        check("pause_on", {7'd0, paused}, 8'd1);
        check("pause_moving", {7'd0, moving}, 8'd0);
        press(8'h04);
        step();
        check("pause_discard", {7'd0, pend_valid}, 8'd0);
        press(8'h2C);
        check("pause_off", {7'd0, paused}, 8'd0);
        check("unpause_moving", {7'd0, moving}, 8'd1);
        check("unpause_pend", {7'd0, pend_valid}, 8'd0);

        // Reversal away from a tile.
        do_reset();
        press(8'h07);
        probe_cycle(1'b1);
        check("rev_setup", {6'd0, cur_dir}, 8'd3);
        press(8'h04);
        check("rev_no_probe0", {7'd0, probe_valid}, 8'd0);
        step();
        check("rev_no_probe1", {7'd0, probe_valid}, 8'd0);
`ifdef PACMAN_INSTANT_REVERSE_EN
        check("rev_cur_dir", {6'd0, cur_dir}, 8'd1);
        check("rev_pend_clr", {7'd0, pend_valid}, 8'd0);
`else
        step();
        check("rev_cur_dir_hold", {6'd0, cur_dir}, 8'd3);
        check("rev_pend", {7'd0, pend_valid}, 8'd1);
        at_tile = 1'b1;
        step();
        at_tile = 1'b0;
        check("rev_probe_dir", {6'd0, probe_dir}, 8'd1);
        probe_done = 1'b1; probe_open = 1'b1;
        step();
        probe_done = 1'b0;
        step();
        check("rev_cur_dir", {6'd0, cur_dir}, 8'd1);
`endif

        // New direction during a probe: in-flight dir unchanged, result discarded.
        do_reset();
        press(8'h07);
        at_tile = 1'b1;
        step();
        at_tile = 1'b0;
        press(8'h1A);
        check("chg_probe_dir", {6'd0, probe_dir}, 8'd3);
        check("chg_probe_valid", {7'd0, probe_valid}, 8'd1);
        probe_done = 1'b1; probe_open = 1'b1;
        step();
        probe_done = 1'b0;
        check("chg_idle", {7'd0, probe_valid}, 8'd0);
        check("chg_pend", {7'd0, pend_valid}, 8'd1);
        step();
        check("chg_cur_dir", {6'd0, cur_dir}, 8'd1);
        check("chg_moving", {7'd0, moving}, 8'd0);

        // Pause during a probe aborts it.
        do_reset();
        press(8'h16);
        at_tile = 1'b1;
        step();
        at_tile = 1'b0;
        press(8'h2C);
        probe_done = 1'b1; probe_open = 1'b1;
        step();
        probe_done = 1'b0;
        step();
        check("pprobe_cur_dir", {6'd0, cur_dir}, 8'd1);
        check("pprobe_idle", {7'd0, probe_valid}, 8'd0);
        check("pprobe_paused", {7'd0, paused}, 8'd1);

        // Reset in the middle of a probe, with a probe_done in the reset cycle.
        do_reset();
        press(8'h07);
        probe_cycle(1'b1);
        press(8'h1A);
        at_tile = 1'b1;
        step();
        at_tile = 1'b0;
        check("midrst_in_probe", {7'd0, probe_valid}, 8'd1);
        Reset = 1'b1; probe_done = 1'b1; probe_open = 1'b1;
        step();
        Reset = 1'b0; probe_done = 1'b0;
        check("midrst_probe_valid", {7'd0, probe_valid}, 8'd0);
        check("midrst_cur_dir", {6'd0, cur_dir}, 8'd1);
        check("midrst_flags", {4'd0, moving, paused, pend_valid, probe_valid}, 8'd0);
        check("midrst_probe_dir", {6'd0, probe_dir}, 8'd0);

        // Randomized debounce/pause/pending run with no tiles.
        picks = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h55};
        do_reset();
        run_key = 0; run_len = 0; m_paused = 0; m_pend = 0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(5) == 0)
                keycode = picks[$urandom_range(6)];
            frame_tick = ($urandom_range(2) == 0);
            step();
            acc = 0;
            k = key_class(keycode);
            if (frame_tick) begin
                if (k == run_key) run_len++;
                else begin run_key = k; run_len = 1; end
                acc = (k != 0) && (run_len == D);
            end
            was_paused = m_paused;
            if (acc && k == 5) m_paused = !m_paused;
            if (was_paused) m_pend = 0;
            else if (acc && k >= 1 && k <= 4) m_pend = 1;
            check("rnd_state", {4'd0, moving, paused, pend_valid, probe_valid},
                  {5'd0, m_paused, m_pend, 1'b0});
        end
        frame_tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pacman_input_ctrl.md
PACMAN_INPUT_CTRL -- requirements
Module: pacman_input_ctrl

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_FRAMES, 2, consecutive frame ticks a keycode must hold before acceptance (range 1..15).
REQ-002 Clk  in  1  system clock; every register is clocked on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 keycode  in  8  USB HID keycode from the SoC keycode export; 0x00 means no key.
REQ-005 frame_tick  in  1  one-Clk pulse per video frame (vsync rise).
REQ-006 at_tile  in  1  Pac-Man is centred on a maze tile this cycle.
REQ-007 probe_valid  out  1  request to the maze logic to test the pending direction.
REQ-008 probe_dir  out  2  direction under test: 0=up, 1=left, 2=down, 3=right.
REQ-009 probe_done  in  1  maze logic result strobe; valid only while probe_valid=1.
REQ-010 probe_open  in  1  tested neighbour tile is walkable; sampled with probe_done.
REQ-011 cur_dir  out  2  committed movement direction.
REQ-012 moving  out  1  a direction is committed and the game is not paused.
REQ-013 paused  out  1  pause state.
REQ-014 pend_valid  out  1  a debounced direction is waiting for commit.

Function
REQ-015 Key decode SHALL be: 0x1A→up, 0x04→left, 0x16→down, 0x07→right, 0x2C→pause, 0x00→none; all other codes SHALL be treated as none.
REQ-016 The debouncer SHALL hold a last-code register and a 4-bit counter; on frame_tick it SHALL increment (saturating) the counter if the decoded key equals the last code, else load the new code and clear the counter to 1.
REQ-017 A key SHALL be accepted on the frame_tick where the counter reaches DEBOUNCE_FRAMES; it SHALL be accepted once per press and not re-accepted while held.
REQ-018 An accepted direction SHALL load the pending register and set pend_valid; a newer accepted direction SHALL overwrite an older pending one.
REQ-019 An accepted pause key SHALL toggle paused; while paused, pending directions SHALL be discarded and no probe SHALL be issued.
REQ-020 FSM states SHALL be IDLE, PROBE, COMMIT.
REQ-021 IDLE→PROBE when pend_valid=1, at_tile=1, paused=0; probe_valid SHALL rise the next cycle with probe_dir = pending direction.
REQ-022 probe_valid and probe_dir SHALL stay stable in PROBE until probe_done=1.
REQ-023 PROBE on probe_done with probe_open=1 → COMMIT; with probe_open=0 → IDLE keeping pend_valid=1 for retry at the next tile.
REQ-024 COMMIT SHALL load cur_dir, set the committed flag, clear pend_valid and return to IDLE in one cycle.
REQ-025 A direction accepted while in PROBE SHALL update the pending register only; the in-flight probe_dir SHALL NOT change and the result SHALL be discarded if the pending direction changed (return to IDLE, pend_valid=1).
REQ-026 Pause toggled during PROBE SHALL abort to IDLE at probe_done; no commit SHALL occur.
REQ-027 moving SHALL equal committed flag AND NOT paused.

Reset
REQ-028 Reset SHALL force: state IDLE, cur_dir=2'd1 (left), committed flag 0, moving=0, paused=0, pend_valid=0, probe_valid=0, probe_dir=0, debounce counter 0, last code none.
REQ-029 Reset asserted mid-probe SHALL drop probe_valid in the following cycle and ignore any probe_done in that cycle.

Configuration
REQ-030 With macro PACMAN_INSTANT_REVERSE_EN defined, an accepted direction opposite to cur_dir while moving=1 SHALL commit directly (IDLE→COMMIT) regardless of at_tile, with no probe; without it, reversals SHALL follow the normal probe path.

Verification
REQ-031 Hold keycode 0x07 for 2 frame_ticks, at_tile=1, probe_open=1 -> probe_dir=3, then cur_dir=3, moving=1, pend_valid=0.
REQ-032 Keycode 0x1A for only 1 frame_tick then 0x00 -> no acceptance, pend_valid stays 0.
REQ-033 Accept 0x16 with probe_open=0 -> state IDLE, pend_valid=1, cur_dir unchanged; next at_tile with probe_open=1 -> cur_dir=2.
REQ-034 Accept 0x2C twice -> paused 1 then 0; moving=0 while paused; pending 0x04 accepted while paused discarded.
REQ-035 cur_dir=3 moving, accept 0x04 at at_tile=0 -> with PACMAN_INSTANT_REVERSE_EN cur_dir=1 within 2 cycles, no probe_valid; without it cur_dir stays 3 until tile probe.
REQ-036 Reset asserted during PROBE -> next cycle probe_valid=0, cur_dir=1, all flags 0.
